serial_adder: RTL and testbench

Bit-serial N-bit adder that consumes the one-bit half-adder cell, one bit per clock, LSB first. The datapath is a full adder built from two half adders and a carry flip-flop, with operand/sum shift registers and a start/busy/done handshake. It sits downstream of the half-adder cell. It is the team's area-minimal sequential alternative to the combinational ripple adder.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/full_addr.sv | 19 +
 rtl/half_addr.sv | 12 +
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_addr.sv
// One-bit full adder composed from two half-adder cells.
module full_addr (
  input  logic in1,
  input  logic in2,
  input  logic cin,
  output logic out,
  output logic cout
);

  logic p;
  logic g0;
  logic g1;

  half_addr u_ha0 (.in1(in1), .in2(in2), .out(p),   .cout(g0));
  half_addr u_ha1 (.in1(p),   .in2(cin), .out(out), .cout(g1));

  assign cout = g0 | g1;

endmodule

// File: rtl/half_addr.sv
// One-bit half-adder cell.
module half_addr (
  input  logic in1,
  input  logic in2,
  output logic out,
  output logic cout
);

  assign out  = in1 ^ in2;
  assign cout = in1 & in2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with start/busy/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned    CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] sh_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;
  logic             capture;
  logic             step;
  logic             finish;

  full_addr u_fa (
    .in1  (a_sh[0]),
    .in2  (b_sh[0]),
    .cin  (carry),
    .out  (s),
    .cout (co)
  );

  // Shift-then-insert form keeps WIDTH=1 legal (no s_sh[WIDTH-1:1] slice).
  always_comb begin
    sh_next          = s_sh >> 1;
    sh_next[WIDTH-1] = s;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          capture    = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      if (capture) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (step) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        s_sh  <= sh_next;
        carry <= co;
        cnt   <= cnt + CW'(1);
      end
      if (finish) begin
        sum  <= sh_next;
        cout <= co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] exp_sum;
    logic       exp_cout;
    bit         b2b;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation; starts now (just after an edge) and returns just after the done edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] exp_sum, input logic exp_cout,
                     input bit reprobe, input string name);
    int unsigned lat;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 20) begin
      chk({name, "_busy"}, busy8, 1);
      if (reprobe && lat == 2) begin
        start8 = 1'b1; a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0;
      end else begin
        start8 = 1'b0;
      end
      tick();
      lat++;
    end
    start8 = 1'b0;
    chk({name, "_latency"}, lat, 8);
    chk({name, "_busy_done"}, busy8, 0);
    chk({name, "_sum"}, sum8, exp_sum);
    chk({name, "_cout"}, cout8, exp_cout);
  endtask

  task automatic idle8(input string name);
    tick();
    chk({name, "_done_pulse"}, done8, 0);
    chk({name, "_idle_busy"}, busy8, 0);
  endtask

  task automatic op1(input logic a, input logic b, input logic c, input string name);
    logic [1:0] exp;
    int unsigned lat;
    exp = 2'(a) + 2'(b) + 2'(c);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 10) begin
      chk({name, "_busy"}, busy1, 1);
      tick();
      lat++;
    end
    chk({name, "_latency"}, lat, 1);
    chk({name, "_result"}, {cout1, sum1}, exp);
    tick();
    chk({name, "_done_pulse"}, done1, 0);
  endtask

  vec_t vecs[6];

  initial begin
    logic [8:0] model;
    logic [7:0] ra, rb;
    logic       rc;
    bit         saw_done;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};

    rst = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick();
    tick();
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_sum", sum8, 0);
    chk("reset_cout", cout8, 0);
    chk("reset_w1", {busy1, done1, sum1, cout1}, 0);
    rst = 1'b1;
    tick();

    // Directed table; b2b entries start while the previous result is in DONE.
    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].b2b && i > 0) idle8($sformatf("vec%0d_pre", i));
      op8(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_sum, vecs[i].exp_cout,
          1'b0, $sformatf("vec%0d", i));
    end
    idle8("vec_end");

    // Start re-pulsed during RUN must not disturb the current op.
    op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1, "ignore_start");
    idle8("ignore_start_after");
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8) saw_done = 1'b1;
    end
    chk("ignore_start_no_second_done", saw_done, 0);

    // Back-to-back with no IDLE cycle in between.
    op8(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, "b2b_first");
    op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "b2b_second");
    idle8("b2b_end");

    // Reset during the third RUN cycle aborts the op and clears the result.
    op8(8'h20, 8'h03, 1'b0, 8'h23, 1'b0, 1'b0, "pre_abort");
    idle8("pre_abort_end");
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) saw_done = 1'b1;
    end
    chk("abort_no_done", saw_done, 0);

    // Random sweep against plain arithmetic.
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      op8(ra, rb, rc, model[7:0], model[8], 1'b0, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle8($sformatf("rand%0d_idle", i));
    end

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1(v[2], v[1], v[0], $sformatf("w1_%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
